// File: rtl/signed_sum_scan_display.sv
// Signed adder with sequential double-dabble conversion and a multiplexed 7-segment scan display.
// Optional build macro: SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits on tubes DIGITS-2..1.
module signed_sum_scan_display #(
  parameter int WIDTH    = 4,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  input  logic              load_i,
  output logic              busy_o,
  output logic              overflow_o,
  output logic [DIGITS-1:0] tub_sel_o,
  output logic [7:0]        tub_control_o
);

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) r = r * 32'd10;
    return r;
  endfunction

  localparam int NB   = DIGITS - 1;
  localparam int BW   = 4 * NB;
  localparam int SW   = WIDTH + 1;
  localparam int CNTW = $clog2(SW);
  localparam int IW   = $clog2(DIGITS);
  localparam int CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [31:0] LIMIT = pow10(NB);

  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hFC;
      4'd1:    return 8'h60;
      4'd2:    return 8'hDA;
      4'd3:    return 8'hF2;
      4'd4:    return 8'h66;
      4'd5:    return 8'hB6;
      4'd6:    return 8'hBE;
      4'd7:    return 8'hE0;
      4'd8:    return 8'hFE;
      4'd9:    return 8'hF6;
      default: return 8'h00;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic [SW-1:0]     sum_q, sum_d;
  logic              sign_q, sign_d;
  logic [SW-1:0]     shift_q, shift_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]     disp_bcd_q, disp_bcd_d;
  logic              disp_sign_q, disp_sign_d;
  logic              disp_ovf_q, disp_ovf_d;
  logic              disp_valid_q, disp_valid_d;
  logic [CW-1:0]     scan_q, scan_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [7:0]        seg_q, seg_d;

  logic [SW-1:0]     sum_ext, mag_ext, mag_cur;
  logic [BW-1:0]     bcd_adj, bcd_step;
  logic              lead_nz;

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    sum_d        = sum_q;
    sign_d       = sign_q;
    shift_d      = shift_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    disp_bcd_d   = disp_bcd_q;
    disp_sign_d  = disp_sign_q;
    disp_ovf_d   = disp_ovf_q;
    disp_valid_d = disp_valid_q;

    sum_ext = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i};
    mag_ext = sum_ext[WIDTH] ? (~sum_ext + 1'b1) : sum_ext;
    mag_cur = sum_q[WIDTH] ? (~sum_q + 1'b1) : sum_q;

    // Double-dabble: digits only carry upward, so the truncated upper digits never disturb the shown ones.
    bcd_adj = bcd_q;
    for (int i = 0; i < NB; i++)
      if (bcd_adj[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
    bcd_step = {bcd_adj[BW-2:0], shift_q[SW-1]};

    case (state_q)
      IDLE, SHOW: begin
        if (load_i) begin
          state_d = CONV;
          busy_d  = 1'b1;
          sum_d   = sum_ext;
          sign_d  = sum_ext[WIDTH];
          shift_d = mag_ext;
          bcd_d   = '0;
          cnt_d   = CNTW'(WIDTH);
        end
      end
      CONV: begin
        bcd_d   = bcd_step;
        shift_d = shift_q << 1;
        if (cnt_q == '0) begin
          state_d      = SHOW;
          busy_d       = 1'b0;
          disp_bcd_d   = bcd_step;
          disp_sign_d  = sign_q;
          disp_ovf_d   = (32'(mag_cur) >= LIMIT);
          disp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (scan_q == '0) begin
      scan_d = CW'(SCAN_DIV - 1);
      idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      scan_d = scan_q - 1'b1;
      idx_d  = idx_q;
    end
    sel_d = {{(DIGITS-1){1'b0}}, 1'b1} << idx_d;

    lead_nz = 1'b0;
    for (int i = 0; i < NB; i++)
      if (i >= int'(idx_d) && disp_bcd_d[4*i +: 4] != 4'd0) lead_nz = 1'b1;

    // Segment pattern follows the next-state display so tub_control stays aligned with tub_sel.
    if (!disp_valid_d) begin
      seg_d = (idx_d == '0) ? 8'hFC : 8'h00;
    end else if (disp_ovf_d) begin
      seg_d = 8'h9E;
    end else if (idx_d == IW'(DIGITS - 1)) begin
      seg_d = disp_sign_d ? 8'b0000_0010 : 8'h00;
    end else begin
      seg_d = seg7(disp_bcd_d[int'(idx_d)*4 +: 4]);
`ifdef SSD_LEADING_ZERO_BLANK_EN
      if (idx_d != '0 && !lead_nz) seg_d = 8'h00;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      sum_q        <= '0;
      sign_q       <= 1'b0;
      shift_q      <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      disp_bcd_q   <= '0;
      disp_sign_q  <= 1'b0;
      disp_ovf_q   <= 1'b0;
      disp_valid_q <= 1'b0;
      scan_q       <= CW'(SCAN_DIV - 1);
      idx_q        <= '0;
      sel_q        <= {{(DIGITS-1){1'b0}}, 1'b1};
      seg_q        <= 8'hFC;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      sum_q        <= sum_d;
      sign_q       <= sign_d;
      shift_q      <= shift_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_sign_q  <= disp_sign_d;
      disp_ovf_q   <= disp_ovf_d;
      disp_valid_q <= disp_valid_d;
      scan_q       <= scan_d;
      idx_q        <= idx_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
    end
  end

  assign busy_o        = busy_q;
  assign overflow_o    = disp_ovf_q;
  assign tub_sel_o     = sel_q;
  assign tub_control_o = seg_q;

endmodule

// File: doc/signed_sum_scan_display.md
SIGNED_SUM_SCAN_DISPLAY -- requirements
Module: signed_sum_scan_display

Interface
REQ-001 Parameter WIDTH, default 4: two's-complement operand width, legal range 2..16.
REQ-002 Parameter DIGITS, default 4: number of scanned tubes, legal range 2..8; tube DIGITS-1 is leftmost.
REQ-003 Parameter SCAN_DIV, default 100000: clk cycles each tube stays selected, legal range >=1.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 a  input  WIDTH  signed operand A.
REQ-007 b  input  WIDTH  signed operand B.
REQ-008 load  input  1  single-cycle request to capture a+b.
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 overflow  output  1  high while the displayed magnitude exceeds the DIGITS-1 decimal digit capacity.
REQ-011 tub_sel  output  DIGITS  one-hot tube enable, active high.
REQ-012 tub_control  output  8  segments {a,b,c,d,e,f,g,dp}, active high; dp is always 0.

Function
REQ-013 The FSM SHALL have three states: IDLE, CONV, SHOW.
- IDLE->CONV on load.
- CONV->SHOW after exactly WIDTH+1 shift cycles.
- SHOW->CONV on load.
REQ-014 On load in IDLE or SHOW, the block SHALL register sum = sign-extended a + sign-extended b as WIDTH+1 bits; this addition can never overflow.
REQ-015 The block SHALL latch sign = sum MSB and convert |sum| to BCD with sequential double-dabble, one bit per cycle.
REQ-016 busy SHALL be high for the WIDTH+1 CONV cycles, rising the cycle after load is sampled.
REQ-017 The display registers SHALL update in the cycle CONV exits; the previous value is shown throughout CONV.
REQ-018 load while busy is high SHALL be ignored.
REQ-019 Tube DIGITS-1 SHALL show '-' (8'b0000_0010) when sign=1 and blank (8'h00) otherwise.
REQ-020 Tubes DIGITS-2..0 SHALL show the BCD digits of |sum|, least significant digit on tube 0.
REQ-021 Digit encodings SHALL be: 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6 (hex).
REQ-022 If |sum| >= 10^(DIGITS-1), overflow SHALL be 1 and every tube SHALL show 'E' (8'h9E).
REQ-023 The scan counter SHALL select tube k for SCAN_DIV cycles, then tube k+1, wrapping from DIGITS-1 to 0; scanning runs in every state, independent of load.
REQ-024 tub_control SHALL be a registered output aligned with tub_sel in the same cycle.

Reset
REQ-025 When rst=1 at a clock edge, the block SHALL:
- enter IDLE with busy=0, overflow=0;
- clear sum, sign and BCD to zero;
- reset the scan counter so that tub_sel = 1 (tube 0 selected);
- drive tub_control = 8'hFC on tube 0 and 8'h00 elsewhere (display "0").
REQ-026 rst SHALL win over a simultaneous load, including mid-CONV; the partial conversion is discarded.

Configuration
REQ-027 Macro SSD_LEADING_ZERO_BLANK_EN, when defined, SHALL blank leading zero digits on tubes DIGITS-2..1; tube 0 always shows a digit. The '-' sign stays on tube DIGITS-1, not adjacent to the number.
REQ-028 Without SSD_LEADING_ZERO_BLANK_EN, all tubes DIGITS-2..0 SHALL show their digit including leading zeros.

Verification (WIDTH=4, DIGITS=4, SCAN_DIV=4 unless stated)
REQ-029 a=-8, b=-8, load -> busy high for 5 cycles, then tubes 3..0 = 02,FC,60,BE ("-016"); with macro = 02,00,60,BE.
REQ-030 a=7, b=7, load -> tubes = 00,FC,60,66 ("014"), overflow=0.
REQ-031 WIDTH=8, DIGITS=3: a=127, b=127, load -> sum 254 >= 100, overflow=1, all tubes 9E.
REQ-032 Second load issued 2 cycles into CONV -> ignored; the first result is displayed and busy stays high exactly 5 cycles.
REQ-033 rst asserted mid-CONV -> next cycle busy=0, tub_sel=0001, tub_control=FC; scan then rotates 0001->0010->0100->1000->0001 every 4 cycles.
